note_decoder: RTL
=================

// Module: note_decoder
// PURPOSE
//  Consumes the 5-bit notecode from the keypad encoder and drives a square-wave
//  tone on audio_out toward the speaker/amp pin. It filters out short-lived
//  notecode glitches and maps each code to a fixed half-period count at 5 MHz.
//  It changes pitch only on half-period boundaries, so no runt pulses appear.
// PARAMETERS
//  STABLE_CYCLES  5000  consecutive cycles a code must hold before acceptance (1 ms)
//  CNT_W          14    half-period counter width (max half = 9556 < 2^14)
// PORTS
//  clk_5MHz     in   1  system clock, 5 MHz
//  rst_n        in   1  asynchronous, active-low reset
//  notecode     in   5  0 = no key; 1-7 octave4 C..B; 8-14 octave5; 15-21 octave6
//  audio_out    out  1  square-wave tone, 50% duty
//  note_active  out  1  1 while in PLAY state
//  cur_note     out  5  notecode currently sounding; 0 when idle
// BEHAVIOUR
//  Reset: all regs cleared asynchronously; audio_out=0, note_active=0, cur_note=0,
//   state=IDLE, accepted code=0. Reset asserted mid-tone silences output at once.
//  Input filter: n_q<=notecode each edge. If n_q!=cand: cand<=n_q, stab<=0.
//   Else if stab!=STABLE_CYCLES-1: stab++. Else accepted<=cand.
//   accepted updates STABLE_CYCLES+2 edges after a held notecode change.
//  Valid = accepted in 1..21; 0 and 22..31 = silent.
//  Half-period table, base octave 4 (k=1..7 = C D E F G A B):
//   9556 8513 7584 7159 6378 5682 5062.
//   Code c: k=((c-1)%7)+1, oct=(c-1)/7, HALF = BASE[k] >> oct (truncate).
//   Codes 8-14: 4778 4256 3792 3579 3189 2841 2531.
//   Codes 15-21: 2389 2128 1896 1789 1594 1420 1265.
//  FSM IDLE:
//   if accepted valid: cur_note<=accepted, cnt<=HALF-1, audio_out<=1,
//   note_active<=1, ->PLAY. Else hold, audio_out=0.
//  FSM PLAY:
//   if cnt!=0: cnt--.
//   cnt==0 (boundary), accepted valid: audio_out toggles, cur_note<=accepted,
//    cnt<=HALF(accepted)-1.
//   cnt==0, accepted silent: audio_out<=0, cur_note<=0, note_active<=0, ->IDLE.
//  Each phase lasts exactly HALF cycles; period = 2*HALF.
//  Boundaries use pre-edge accepted value; an accept update coincident with a
//   boundary takes effect at the next boundary.
//  A pitch change or release never truncates the phase in progress. A release
//   during a low phase ends the low phase, then goes IDLE (no extra high pulse).
//  Same note re-accepted: no visible effect.
// TESTING  (STABLE_CYCLES=4)
//  Reset, notecode=0 for 1000 cycles -> audio_out=0, note_active=0, cur_note=0.
//  notecode 0->6 held -> audio_out rises 7 edges after change; high 5682, low 5682
//   cycles; cur_note=6.
//  notecode=21 held -> period 2530 cycles (1265 high/1265 low), cur_note=21.
//  6->13 mid high phase -> that phase completes at 5682; later phases 2841; cur_note=13.
//  While idle, notecode=8 for 3 cycles then 0 -> no output activity.
//  Release to 0 mid high phase -> phase completes, audio_out=0, note_active=0.
//   notecode=25 -> stays silent. rst_n low mid-tone -> all outputs 0 immediately.

Source files
------------

// File: rtl/note_decoder.sv
// note_decoder: debounces the keypad notecode and plays the matching square
// wave tone at 50% duty. Pitch and release changes only take effect on
// half-period boundaries, so every phase lasts a full HALF cycles.
module note_decoder #(
    parameter int STABLE_CYCLES = 5000,
    parameter int CNT_W         = 14
) (
    input  logic       clk_5MHz,
    input  logic       rst_n,
    input  logic [4:0] notecode,
    output logic       audio_out,
    output logic       note_active,
    output logic [4:0] cur_note
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state, state_nx;
    logic [4:0]        n_q, cand, accepted;
    logic [STAB_W-1:0] stab;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              audio_nx, active_nx;
    logic [4:0]        note_nx;
    logic              acc_valid;
    logic [CNT_W-1:0]  acc_half;

    // Half-period in 5 MHz cycles: octave-4 base count shifted down per octave.
    function automatic logic [CNT_W-1:0] half_of(input logic [4:0] c);
        logic [4:0]       k;
        logic [1:0]       oct;
        logic [CNT_W-1:0] base;
        if (c <= 5'd7) begin
            k = c;            oct = 2'd0;
        end else if (c <= 5'd14) begin
            k = c - 5'd7;     oct = 2'd1;
        end else begin
            k = c - 5'd14;    oct = 2'd2;
        end
        case (k)
            5'd1:    base = CNT_W'(9556);
            5'd2:    base = CNT_W'(8513);
            5'd3:    base = CNT_W'(7584);
            5'd4:    base = CNT_W'(7159);
            5'd5:    base = CNT_W'(6378);
            5'd6:    base = CNT_W'(5682);
            5'd7:    base = CNT_W'(5062);
            default: base = '0;
        endcase
        return base >> oct;
    endfunction

    assign acc_valid = (accepted != 5'd0) && (accepted <= 5'd21);
    assign acc_half  = half_of(accepted);

    // Glitch filter: a code must hold STABLE_CYCLES cycles in cand before it is accepted.
    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= '0;
            cand     <= '0;
            stab     <= '0;
            accepted <= '0;
        end else begin
            n_q <= notecode;
            if (n_q != cand) begin
                cand <= n_q;
                stab <= '0;
            end else if (stab != STAB_MAX) begin
                stab <= stab + 1'b1;
            end else begin
                accepted <= cand;
            end
        end
    end

    // Tone state register: FSM state, phase counter and registered outputs.
    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            audio_out   <= 1'b0;
            note_active <= 1'b0;
            cur_note    <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            audio_out   <= audio_nx;
            note_active <= active_nx;
            cur_note    <= note_nx;
        end
    end

    // Next state: pitch/release decisions are only made when cnt reaches 0.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        audio_nx  = audio_out;
        active_nx = note_active;
        note_nx   = cur_note;
        case (state)
            IDLE: begin
                audio_nx = 1'b0;
                if (acc_valid) begin
                    note_nx   = accepted;
                    cnt_nx    = acc_half - CNT_W'(1);
                    audio_nx  = 1'b1;
                    active_nx = 1'b1;
                    state_nx  = PLAY;
                end
            end
            PLAY: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else if (acc_valid) begin
                    audio_nx = ~audio_out;
                    note_nx  = accepted;
                    cnt_nx   = acc_half - CNT_W'(1);
                end else begin
                    // Release: the phase just finished, so drop straight to silence.
                    audio_nx  = 1'b0;
                    note_nx   = '0;
                    active_nx = 1'b0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
